// File: rtl/inst_fetch_if.sv
// Instruction-fetch interface stage.
// Issues one SRAM-like fetch at a time and buffers the word for decode.
module inst_fetch_if #(
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          pc_ce,
  input  logic [DW-1:0] pc,
  input  logic          stall_id,
  input  logic          flush,
  output logic          pc_en,
  output logic          inst_req,
  output logic [DW-1:0] inst_addr,
  input  logic          inst_addr_ok,
  input  logic [DW-1:0] inst_rdata,
  input  logic          inst_data_ok,
  output logic          if_valid,
  output logic [DW-1:0] if_pc,
  output logic [DW-1:0] if_inst,
  output logic          if_adel
);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    DATA,
    OUT
  } state_t;

  state_t        state;
  state_t        state_nx;
  logic          cancel;
  logic          cancel_nx;
  logic [DW-1:0] req_addr;
  logic [DW-1:0] req_pc;
  logic [DW-1:0] pc_phys;
  logic          pc_mis;
  logic          start;
  logic          latch;
  logic          cap_data;
  logic          cap_adel;

  // kseg0/kseg1 fold onto the low 512 MB of physical space
  assign pc_phys = (pc[DW-1:DW-2] == 2'b10) ?
                   {3'b000, pc[DW-4:0]} : pc;
  assign pc_mis  = (pc[1:0] != 2'b00);
  assign start   = (state == IDLE) & pc_ce & ~flush;
  assign if_valid = (state == OUT);

  // next state, bus request and PC enable
  always_comb begin
    state_nx  = state;
    cancel_nx = cancel;
    inst_req  = 1'b0;
    inst_addr = req_addr;
    pc_en     = flush;
    latch     = 1'b0;
    cap_data  = 1'b0;
    cap_adel  = 1'b0;
    unique case (state)
      IDLE: begin
        inst_addr = pc_phys;
        if (start && !pc_mis) begin
          inst_req = 1'b1;
          latch    = 1'b1;
          state_nx = inst_addr_ok ? DATA : REQ;
        end else if (start) begin
          cap_adel = 1'b1;
          state_nx = OUT;
        end
      end
      REQ: begin
        inst_req = 1'b1;
        if (flush) cancel_nx = 1'b1;
        if (inst_addr_ok) state_nx = DATA;
      end
      DATA: begin
        if (inst_data_ok) begin
          cancel_nx = 1'b0;
          if (cancel || flush) begin
            state_nx = IDLE;
          end else begin
            cap_data = 1'b1;
            state_nx = OUT;
          end
        end else if (flush) begin
          cancel_nx = 1'b1;
        end
      end
      OUT: begin
        if (flush) begin
          state_nx = IDLE;
        end else if (!stall_id) begin
          pc_en    = 1'b1;
          state_nx = IDLE;
        end
      end
    endcase
  end

  // state, request latch and decode-side output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cancel   <= 1'b0;
      req_addr <= '0;
      req_pc   <= '0;
      if_pc    <= '0;
      if_inst  <= '0;
      if_adel  <= 1'b0;
    end else begin
      state  <= state_nx;
      cancel <= cancel_nx;
      if (latch) begin
        req_pc   <= pc;
        req_addr <= pc_phys;
      end
      if (cap_adel) begin
        if_pc   <= pc;
        if_inst <= '0;
        if_adel <= 1'b1;
      end else if (cap_data) begin
        if_pc   <= req_pc;
        if_inst <= inst_rdata;
        if_adel <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_inst_fetch_if.sv
// Directed bench for inst_fetch_if with a transaction-level model.
// A small bus responder supplies configurable addr_ok/data_ok delays.
module tb_inst_fetch_if;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        pc_ce = 1'b0;
  logic [31:0] pc = '0;
  logic        stall_id = 1'b0;
  logic        flush = 1'b0;
  logic        pc_en;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_addr_ok = 1'b0;
  logic [31:0] inst_rdata = '0;
  logic        inst_data_ok = 1'b0;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_inst;
  logic        if_adel;

  int total = 0;
  int bad = 0;

  int aw = 0;
  int dw = 0;

  inst_fetch_if #(.DW(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .pc_ce        (pc_ce),
    .pc           (pc),
    .stall_id     (stall_id),
    .flush        (flush),
    .pc_en        (pc_en),
    .inst_req     (inst_req),
    .inst_addr    (inst_addr),
    .inst_addr_ok (inst_addr_ok),
    .inst_rdata   (inst_rdata),
    .inst_data_ok (inst_data_ok),
    .if_valid     (if_valid),
    .if_pc        (if_pc),
    .if_inst      (if_inst),
    .if_adel      (if_adel)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] xl(input logic [31:0] a);
    if (a[31:30] == 2'b10) return {3'b000, a[28:0]};
    return a;
  endfunction

  function automatic logic [31:0] memw(input logic [31:0] a);
    if (a == 32'h1FC00000) return 32'h3C080001;
    return a ^ 32'hDEAD0000;
  endfunction

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t",
               nm, act, exp, $time);
    end
  endtask

  // bus responder: aw wait cycles before addr_ok,
  // dw extra cycles between acceptance and data_ok
  logic        busy = 1'b0;
  int          acnt = 0;
  int          dcnt = 0;
  logic [31:0] baddr = '0;
  always @(posedge clk) begin
    #2;
    inst_addr_ok = 1'b0;
    inst_data_ok = 1'b0;
    if (rst) begin
      busy = 1'b0;
      acnt = 0;
    end else if (busy) begin
      if (dcnt == 0) begin
        inst_data_ok = 1'b1;
        inst_rdata   = memw(baddr);
        busy         = 1'b0;
      end else begin
        dcnt--;
      end
    end else if (inst_req) begin
      if (acnt >= aw) begin
        inst_addr_ok = 1'b1;
        busy         = 1'b1;
        baddr        = inst_addr;
        dcnt         = dw;
        acnt         = 0;
      end else begin
        acnt++;
      end
    end
  end

  // model: a pending fetch (issued / accepted / killed) or a
  // presented instruction; the word shown is what decode must see
  logic        m_pend = 1'b0;
  logic        m_acc  = 1'b0;
  logic        m_dead = 1'b0;
  logic [31:0] m_ppc  = '0;
  logic        m_show = 1'b0;
  logic [31:0] m_pc   = '0;
  logic [31:0] m_inst = '0;
  logic        m_adel = 1'b0;

  initial begin
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_pen;
    @(posedge clk);
    forever begin
      @(negedge clk);
      if (m_pend) e_req = !m_acc;
      else e_req = !m_show && pc_ce && !flush && (pc[1:0] == 2'b00);
      e_addr = m_pend ? xl(m_ppc) : xl(pc);
      e_pen  = flush || (m_show && !stall_id);
      chk("m_req", {31'b0, inst_req}, {31'b0, e_req});
      if (e_req) chk("m_addr", inst_addr, e_addr);
      chk("m_pc_en", {31'b0, pc_en}, {31'b0, e_pen});
      chk("m_valid", {31'b0, if_valid}, {31'b0, m_show});
      chk("m_if_pc", if_pc, m_pc);
      chk("m_if_inst", if_inst, m_inst);
      chk("m_if_adel", {31'b0, if_adel}, {31'b0, m_adel});
      if (rst) begin
        m_pend = 0; m_acc = 0; m_dead = 0; m_show = 0;
        m_pc = '0; m_inst = '0; m_adel = 0;
      end else if (m_show) begin
        if (flush || !stall_id) m_show = 0;
      end else if (!m_pend) begin
        if (pc_ce && !flush) begin
          if (pc[1:0] == 2'b00) begin
            m_pend = 1; m_ppc = pc;
            m_acc = inst_addr_ok; m_dead = 0;
          end else begin
            m_show = 1; m_pc = pc;
            m_inst = '0; m_adel = 1;
          end
        end
      end else if (!m_acc) begin
        m_acc = inst_addr_ok;
        if (flush) m_dead = 1;
      end else if (inst_data_ok) begin
        m_pend = 0;
        if (!m_dead && !flush) begin
          m_show = 1; m_pc = m_ppc;
          m_inst = inst_rdata; m_adel = 0;
        end
      end else if (flush) begin
        m_dead = 1;
      end
    end
  end

  task automatic tick(input logic r, input logic ce,
                      input logic [31:0] p,
                      input logic st, input logic fl);
    @(posedge clk);
    #1;
    rst = r; pc_ce = ce; pc = p;
    stall_id = st; flush = fl;
    @(negedge clk);
  endtask

  initial begin
    tick(1, 0, 32'h0, 0, 0);
    tick(1, 0, 32'h0, 0, 0);
    chk("rst_valid", {31'b0, if_valid}, 32'd0);
    chk("rst_pc_en", {31'b0, pc_en}, 32'd0);
    chk("rst_req", {31'b0, inst_req}, 32'd0);
    chk("rst_if_pc", if_pc, 32'd0);
    chk("rst_if_inst", if_inst, 32'd0);
    chk("rst_if_adel", {31'b0, if_adel}, 32'd0);

    // first fetch after reset, zero-wait bus
    tick(0, 0, 32'hBFC00000, 0, 0);
    chk("ce0_req", {31'b0, inst_req}, 32'd0);
    tick(0, 1, 32'hBFC00000, 0, 0);
    chk("f1_req", {31'b0, inst_req}, 32'd1);
    chk("f1_addr", inst_addr, 32'h1FC00000);
    tick(0, 1, 32'hBFC00000, 0, 0);
    chk("f1_data_valid", {31'b0, if_valid}, 32'd0);
    tick(0, 1, 32'hBFC00000, 0, 0);
    chk("f1_valid", {31'b0, if_valid}, 32'd1);
    chk("f1_inst", if_inst, 32'h3C080001);
    chk("f1_pc", if_pc, 32'hBFC00000);
    chk("f1_pc_en", {31'b0, pc_en}, 32'd1);

    // addr_ok held off 3 cycles while pc moves
    aw = 3;
    tick(0, 1, 32'hBFC00004, 0, 0);
    chk("f2_req", {31'b0, inst_req}, 32'd1);
    chk("f2_addr", inst_addr, 32'h1FC00004);
    chk("f2_pc_en", {31'b0, pc_en}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick(0, 1, 32'hBFC00040 + 32'(i * 4), 0, 0);
      chk("f2_hold_req", {31'b0, inst_req}, 32'd1);
      chk("f2_hold_addr", inst_addr, 32'h1FC00004);
    end
    aw = 0;
    tick(0, 1, 32'hBFC00040, 0, 0);
    chk("f2_data_valid", {31'b0, if_valid}, 32'd0);

    // decode stalls 4 cycles
    for (int i = 0; i < 4; i++) begin
      tick(0, 1, 32'hBFC00004, 1, 0);
      chk("stall_valid", {31'b0, if_valid}, 32'd1);
      chk("stall_inst", if_inst, 32'hC16D0004);
      chk("stall_pc", if_pc, 32'hBFC00004);
      chk("stall_pc_en", {31'b0, pc_en}, 32'd0);
    end
    tick(0, 1, 32'hBFC00004, 0, 0);
    chk("rel_pc_en", {31'b0, pc_en}, 32'd1);

    // flush while waiting for data
    dw = 2;
    tick(0, 1, 32'hBFC00008, 0, 0);
    chk("f3_addr", inst_addr, 32'h1FC00008);
    tick(0, 1, 32'hBFC00008, 0, 1);
    chk("fl_pc_en", {31'b0, pc_en}, 32'd1);
    tick(0, 1, 32'h80000100, 0, 0);
    chk("fl_valid_a", {31'b0, if_valid}, 32'd0);
    tick(0, 1, 32'h80000100, 0, 0);
    chk("fl_valid_b", {31'b0, if_valid}, 32'd0);
    dw = 0;
    tick(0, 1, 32'h80000100, 0, 0);
    chk("fl_valid_c", {31'b0, if_valid}, 32'd0);
    chk("fl_new_req", {31'b0, inst_req}, 32'd1);
    chk("fl_new_addr", inst_addr, 32'h00000100);
    tick(0, 1, 32'h80000100, 0, 0);
    tick(0, 1, 32'h80000100, 0, 0);
    chk("f4_valid", {31'b0, if_valid}, 32'd1);
    chk("f4_pc", if_pc, 32'h80000100);
    chk("f4_inst", if_inst, 32'hDEAD0100);

    // misaligned pc
    tick(0, 1, 32'hBFC00002, 0, 0);
    chk("adel_req", {31'b0, inst_req}, 32'd0);
    tick(0, 1, 32'hBFC00002, 0, 0);
    chk("adel_valid", {31'b0, if_valid}, 32'd1);
    chk("adel_flag", {31'b0, if_adel}, 32'd1);
    chk("adel_inst", if_inst, 32'd0);
    chk("adel_pc", if_pc, 32'hBFC00002);

    // flush coincident with data_ok
    tick(0, 1, 32'hBFC00010, 0, 0);
    tick(0, 1, 32'hBFC00010, 0, 1);
    chk("fd_pc_en", {31'b0, pc_en}, 32'd1);
    tick(0, 1, 32'hBFC00020, 0, 0);
    chk("fd_valid", {31'b0, if_valid}, 32'd0);
    chk("fd_addr", inst_addr, 32'h1FC00020);
    tick(0, 1, 32'hBFC00020, 0, 0);
    tick(0, 1, 32'hBFC00020, 0, 0);
    chk("fd_next_valid", {31'b0, if_valid}, 32'd1);
    chk("fd_next_inst", if_inst, 32'hC16D0020);

    // repeated flush during REQ, idle flush, flush in OUT
    aw = 2; dw = 1;
    tick(0, 1, 32'hBFC00030, 0, 0);
    tick(0, 1, 32'hBFC00030, 0, 1);
    tick(0, 1, 32'hBFC00034, 0, 1);
    chk("rf_pc_en", {31'b0, pc_en}, 32'd1);
    aw = 0; dw = 0;
    tick(0, 1, 32'hBFC00038, 0, 0);
    tick(0, 1, 32'hBFC00038, 0, 0);
    chk("rf_valid", {31'b0, if_valid}, 32'd0);
    tick(0, 1, 32'hBFC00040, 0, 1);
    chk("if_req", {31'b0, inst_req}, 32'd0);
    chk("if_pc_en", {31'b0, pc_en}, 32'd1);
    tick(0, 1, 32'hBFC00044, 0, 0);
    tick(0, 1, 32'hBFC00044, 1, 0);
    tick(0, 1, 32'hBFC00044, 1, 1);
    chk("of_valid", {31'b0, if_valid}, 32'd1);
    tick(0, 1, 32'hBFC00048, 0, 0);
    chk("of_drop", {31'b0, if_valid}, 32'd0);
    tick(0, 1, 32'hBFC00048, 0, 0);
    tick(0, 1, 32'hBFC00048, 0, 0);
    for (int i = 0; i < 4; i++) tick(0, 0, 32'h0, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
